fp_instr_encoder: RTL and testbench
===================================

Name: fp_instr_encoder

Overview:
- Inverse of the FP control-unit decode. Takes micro-op requests (ALU control code, register indices, immediate) and assembles 32-bit instruction words in the FP ISA format.
- Buffers encoded words in a small FIFO and tags each word with an incrementing instruction-memory byte address.
- Sits between the test/program generator and the instruction-memory write port. Used to build programs that the decode unit then consumes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 16, width of the instruction byte address.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  request valid.
- op_ready  output  1  encoder can accept a request.
- op_code  input  4  ALU control code, 0000..1011.
- op_imm  input  1  selects I-form for code 0000 (ADDI rather than ADD).
- op_rs  input  5  rs field.
- op_rt  input  5  rt field.
- op_rd  input  5  rd field; ignored for I-form.
- op_imm16  input  16  immediate; ignored for R-form.
- addr_load  input  1  load the write address counter.
- addr_base  input  ADDR_W  value loaded when addr_load is high.
- instr_valid  output  1  head FIFO entry valid.
- instr_ready  input  1  consumer accepts the head entry.
- instr  output  32  encoded word at the FIFO head.
- instr_addr  output  ADDR_W  byte address of the head word.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- illegal  output  1  one-cycle pulse, registered, when an illegal request is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; write address counter = 0.
  - instr_valid=0, instr=0, instr_addr=0, level=0, illegal=0, op_ready=1.
- Encoding, R-form: codes 0000 (with op_imm=0) through 1000.
  - instr = {6'b110000, rs, rt, rd, 5'b0, 2'b00, op_code}.
- Encoding, I-form: instr = {opcode, rs, rt, imm16}.
  - 1001 → opcode 110001 (LW).
  - 1010 → opcode 110010 (SW).
  - 1011 → opcode 110100 (LUI).
  - 0000 with op_imm=1 → opcode 110011 (ADDI).
  - Codes 1001..1011 are I-form regardless of op_imm.
- Illegal requests: codes 1100..1111, or codes 0001..1000 with op_imm=1.
- Input handshake:
  - Accept when op_valid && op_ready; op_ready = (level != DEPTH).
  - op_ready depends only on FIFO state, never on op_valid.
- Output handshake:
  - instr_valid = (level != 0).
  - Pop when instr_valid && instr_ready.
  - instr and instr_addr hold stable while instr_valid is high and instr_ready is low.
- Latency: an accepted word is visible at the output on the next cycle if the FIFO was empty. No combinational pass-through.
- Simultaneous push and pop:
  - When not full: both occur and level is unchanged.
  - When full: op_ready=0, so only the pop occurs; op_ready rises next cycle.
- Address assignment:
  - Each pushed word is tagged with the current counter value; the counter then advances by 4.
  - The counter wraps modulo 2^ADDR_W (0xFFFC + 4 → 0x0000).
- addr_load:
  - Loads the counter to {addr_base[ADDR_W-1:2], 2'b00}.
  - If a push occurs in the same cycle, the pushed word is tagged with the loaded base and the counter becomes base+4.
  - Entries already queued keep their addresses.
- FIFO pointers wrap modulo DEPTH. level saturates logically at 0..DEPTH, enforced by the handshake.
- Reset mid-operation: all queued entries are discarded immediately; the counter returns to 0.

Optional Feature:
- Macro: FP_ENC_ILLEGAL_NOP_EN
- Defined: an accepted illegal request pushes the NOP word 32'h00000000, which consumes an address slot, and pulses illegal.
- Undefined: an accepted illegal request is consumed (op_ready handshake completes) and pulses illegal. Nothing is pushed and the counter does not advance.

Test Plan:
- After reset, ADD: code 0000, op_imm=0, rs=1, rt=2, rd=3 → next cycle instr_valid=1, instr=0xC0221800, instr_addr=0x0000, level=1.
- Back-to-back requests with instr_ready=1:
  - LW: rs=4, rt=5, imm=0x0010 → 0xC4850010 @0x0000.
  - DIV: rs=7, rt=8, rd=9 → 0xC0E84803 @0x0004.
  - LUI: rt=6, imm=0xABCD → 0xD006ABCD @0x0008.
  - ADDI: rs=1, rt=2, imm=0xFFFF → 0xCC22FFFF @0x000C.
- Hold instr_ready=0 and push 4 requests → level=4, op_ready=0, head unchanged. Raise instr_ready for one cycle with op_valid=1 → pop only; op_ready=1 the following cycle.
- addr_load=1 with addr_base=0xFFFC, coincident with a push, then a second push → addresses 0xFFFC then 0x0000.
- Illegal code 1101, then ADD rs=1, rt=2, rd=3:
  - Macro undefined → illegal pulses for one cycle; single output 0xC0221800 @0x0000.
  - Macro defined → outputs 0x00000000 @0x0000, then 0xC0221800 @0x0004.
- Assert rst_n=0 asynchronously with level=3 → instr_valid=0 and level=0 without waiting for a clock edge. After release, the next push is tagged 0x0000.

Source files
------------

// File: rtl/fp_instr_encoder.sv
// FP instruction encoder: turns micro-op requests into 32-bit FP ISA words, queued in a FIFO
// with byte addresses. Define FP_ENC_ILLEGAL_NOP_EN to push a NOP for illegal requests.
module fp_instr_encoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [3:0]                 op_code,
    input  logic                       op_imm,
    input  logic [4:0]                 op_rs,
    input  logic [4:0]                 op_rt,
    input  logic [4:0]                 op_rd,
    input  logic [15:0]                op_imm16,
    input  logic                       addr_load,
    input  logic [ADDR_W-1:0]          addr_base,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr,
    output logic [ADDR_W-1:0]          instr_addr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       illegal
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [31:0]       data_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              illegal_q;

    logic [31:0]       enc_word;
    logic              is_illegal;
    logic              accept, push, pop;
    logic [ADDR_W-1:0] tag_addr;

    always_comb begin
        enc_word   = '0;
        is_illegal = 1'b0;
        case (op_code)
            4'b0000: begin
                if (op_imm) enc_word = {6'b110011, op_rs, op_rt, op_imm16};
                else        enc_word = {6'b110000, op_rs, op_rt, op_rd, 5'b0, 2'b00, op_code};
            end
            4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b0110, 4'b0111, 4'b1000: begin
                if (op_imm) is_illegal = 1'b1;
                else        enc_word = {6'b110000, op_rs, op_rt, op_rd, 5'b0, 2'b00, op_code};
            end
            4'b1001: enc_word = {6'b110001, op_rs, op_rt, op_imm16};
            4'b1010: enc_word = {6'b110010, op_rs, op_rt, op_imm16};
            4'b1011: enc_word = {6'b110100, op_rs, op_rt, op_imm16};
            default: is_illegal = 1'b1;
        endcase
    end

    assign op_ready    = (level_q != LVL_W'(DEPTH));
    assign instr_valid = (level_q != '0);
    assign accept      = op_valid && op_ready;
    assign pop         = instr_valid && instr_ready;

`ifdef FP_ENC_ILLEGAL_NOP_EN
    // Illegal requests become a NOP word (enc_word is zero for them) and take an address slot.
    assign push = accept;
`else
    assign push = accept && !is_illegal;
`endif

    // A same-cycle load overrides the counter for the word being pushed.
    assign tag_addr = addr_load ? (addr_base & ~ADDR_W'(3)) : cnt_q;

    assign instr      = instr_valid ? data_q[rd_ptr_q] : '0;
    assign instr_addr = instr_valid ? addr_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign illegal    = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && is_illegal;
            if (push) begin
                data_q[wr_ptr_q] <= enc_word;
                addr_q[wr_ptr_q] <= tag_addr;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                cnt_q            <= tag_addr + ADDR_W'(4);
            end else if (addr_load) begin
                cnt_q <= tag_addr;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_instr_encoder.sv
// Directed testbench for fp_instr_encoder: table of encodings plus FIFO, address and reset
// sequences.
module tb_fp_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_code = '0;
    logic        op_imm = 1'b0;
    logic [4:0]  op_rs = '0, op_rt = '0, op_rd = '0;
    logic [15:0] op_imm16 = '0;
    logic        addr_load = 1'b0;
    logic [15:0] addr_base = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [15:0] instr_addr;
    logic [2:0]  level;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    fp_instr_encoder #(.DEPTH(4), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_imm     (op_imm),
        .op_rs      (op_rs),
        .op_rt      (op_rt),
        .op_rd      (op_rd),
        .op_imm16   (op_imm16),
        .addr_load  (addr_load),
        .addr_base  (addr_base),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_addr (instr_addr),
        .level      (level),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic        imm;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm16;
        logic [31:0] exp_instr;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] code, input logic imm, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm16);
        op_code  = code;
        op_imm   = imm;
        op_rs    = rs;
        op_rt    = rt;
        op_rd    = rd;
        op_imm16 = imm16;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rd ignored for I-form, imm16 ignored for R-form, op_imm ignored for 1001..1011
        vecs[0] = '{4'b0000, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0000, 32'hC0221800, 16'h0000};
        vecs[1] = '{4'b1001, 1'b1, 5'd4, 5'd5, 5'd31, 16'h0010, 32'hC4850010, 16'h0004};
        vecs[2] = '{4'b0011, 1'b0, 5'd7, 5'd8, 5'd9, 16'hFFFF, 32'hC0E84803, 16'h0008};
        vecs[3] = '{4'b1011, 1'b0, 5'd0, 5'd6, 5'd0, 16'hABCD, 32'hD006ABCD, 16'h000C};
        vecs[4] = '{4'b0000, 1'b1, 5'd1, 5'd2, 5'd7, 16'hFFFF, 32'hCC22FFFF, 16'h0010};
        vecs[5] = '{4'b0001, 1'b0, 5'd3, 5'd4, 5'd5, 16'h0000, 32'hC0642801, 16'h0014};
        vecs[6] = '{4'b1010, 1'b0, 5'd2, 5'd3, 5'd0, 16'h1234, 32'hC8431234, 16'h0018};

        // Reset state
        #12;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", 32'(instr_addr), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_ready", 32'(op_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back encodings with the consumer always ready
        instr_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_op(vecs[i].code, vecs[i].imm, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                   vecs[i].imm16);
            op_valid = 1'b1;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'd1);
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_addr", i), 32'(instr_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'd1);
        end
        op_valid = 1'b0;
        tick();
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_valid", 32'(instr_valid), 32'd0);

        // Fill to full with consumer stalled; counter is at 0x001C
        instr_ready = 1'b0;
        op_valid    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(4'b0000, 1'b0, 5'd1, 5'd2, 5'(i), 16'h0);
            tick();
            chk($sformatf("fill%0d_head", i), instr, 32'hC0220000);
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(op_ready), 32'd0);
        chk("full_head_addr", 32'(instr_addr), 32'h001C);
        set_op(4'b0000, 1'b0, 5'd1, 5'd2, 5'd9, 16'h0);
        tick();
        chk("stall_hold_instr", instr, 32'hC0220000);
        chk("stall_level", 32'(level), 32'd4);
        // Pop while full with op_valid high: only the pop happens
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        op_valid    = 1'b0;
        chk("fullpop_level", 32'(level), 32'd3);
        chk("fullpop_ready", 32'(op_ready), 32'd1);
        chk("fullpop_head", instr, 32'hC0220800);
        chk("fullpop_addr", 32'(instr_addr), 32'h0020);
        instr_ready = 1'b1;
        repeat (3) tick();
        chk("fullpop_drain", 32'(level), 32'd0);

        // Address load coincident with a push, unaligned base, then wrap
        instr_ready = 1'b0;
        op_valid    = 1'b1;
        addr_load   = 1'b1;
        addr_base   = 16'hFFFE;
        set_op(4'b0000, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0);
        tick();
        addr_load = 1'b0;
        set_op(4'b0000, 1'b0, 5'd1, 5'd2, 5'd4, 16'h0);
        tick();
        op_valid = 1'b0;
        chk("load_level", 32'(level), 32'd2);
        chk("load_addr0", 32'(instr_addr), 32'hFFFC);
        chk("load_instr0", instr, 32'hC0221800);
        instr_ready = 1'b1;
        tick();
        chk("wrap_addr1", 32'(instr_addr), 32'h0000);
        chk("wrap_instr1", instr, 32'hC0222000);
        tick();
        chk("wrap_drain", 32'(level), 32'd0);

        // Asynchronous reset with three entries queued
        instr_ready = 1'b0;
        op_valid    = 1'b1;
        repeat (3) tick();
        op_valid = 1'b0;
        chk("prerst_level", 32'(level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_instr", instr, 32'd0);
        tick();
        rst_n = 1'b1;

        // Illegal code followed by ADD; counter restarted at 0
        op_valid = 1'b1;
        set_op(4'b1101, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0);
        tick();
        chk("ill_pulse", 32'(illegal), 32'd1);
        set_op(4'b0000, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0);
        tick();
        op_valid = 1'b0;
        chk("ill_pulse_end", 32'(illegal), 32'd0);
`ifdef FP_ENC_ILLEGAL_NOP_EN
        chk("ill_level", 32'(level), 32'd2);
        chk("ill_nop", instr, 32'h00000000);
        chk("ill_nop_addr", 32'(instr_addr), 32'h0000);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("ill_add", instr, 32'hC0221800);
        chk("ill_add_addr", 32'(instr_addr), 32'h0004);
`else
        chk("ill_level", 32'(level), 32'd1);
        chk("ill_add", instr, 32'hC0221800);
        chk("ill_add_addr", 32'(instr_addr), 32'h0000);
`endif
        // R-form code with op_imm set is illegal too
        op_valid = 1'b1;
        set_op(4'b0010, 1'b1, 5'd1, 5'd2, 5'd3, 16'h0);
        tick();
        op_valid = 1'b0;
        chk("ill2_pulse", 32'(illegal), 32'd1);
        tick();
        chk("ill2_pulse_end", 32'(illegal), 32'd0);
`ifdef FP_ENC_ILLEGAL_NOP_EN
        chk("ill2_level", 32'(level), 32'd2);
`else
        chk("ill2_level", 32'(level), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
